// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: Decode operands and control, MEM/WB forward
// sources, hazard controls, and the execute-stage outputs.
interface id_ex_operand_stage_if #(
  parameter int N = 32,
  parameter int R = 5
);
  // Hazard control toward the E registers
  logic         StallE;
  logic         FlushE;

  // Decode-stage operands and control
  logic [N-1:0] RD1D;
  logic [N-1:0] RD2D;
  logic [N-1:0] PCD;
  logic [N-1:0] ImmExtD;
  logic [R-1:0] Rs1D;
  logic [R-1:0] Rs2D;
  logic [R-1:0] RdD;
  logic [2:0]   ALUControlD;
  logic         ALUSrcD;
  logic         RegWriteD;
  logic         MemWriteD;
  logic         BranchD;
  logic         JumpD;
  logic         ValidD;
  logic [1:0]   ResultSrcD;

  // Forward sources from MEM and WB
  logic [N-1:0] ALUResultM;
  logic [R-1:0] RdM;
  logic         RegWriteM;
  logic [N-1:0] ResultW;
  logic [R-1:0] RdW;
  logic         RegWriteW;

  // Execute-stage outputs
  logic [N-1:0] SrcAE;
  logic [N-1:0] SrcBE;
  logic [N-1:0] WriteDataE;
  logic [N-1:0] PCE;
  logic [N-1:0] ImmExtE;
  logic [R-1:0] RdE;
  logic [2:0]   ALUControlE;
  logic         RegWriteE;
  logic         MemWriteE;
  logic         BranchE;
  logic         JumpE;
  logic         ValidE;
  logic [1:0]   ResultSrcE;
  logic [1:0]   ForwardAE;
  logic [1:0]   ForwardBE;
  logic         LoadUseStall;

  modport master (
    output StallE, FlushE,
    output RD1D, RD2D, PCD, ImmExtD, Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD,
    output RegWriteD, MemWriteD, BranchD, JumpD, ValidD, ResultSrcD,
    output ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    input  SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, RdE, ALUControlE,
    input  RegWriteE, MemWriteE, BranchE, JumpE, ValidE, ResultSrcE,
    input  ForwardAE, ForwardBE, LoadUseStall
  );

  modport slave (
    input  StallE, FlushE,
    input  RD1D, RD2D, PCD, ImmExtD, Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD,
    input  RegWriteD, MemWriteD, BranchD, JumpD, ValidD, ResultSrcD,
    input  ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    output SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, RdE, ALUControlE,
    output RegWriteE, MemWriteE, BranchE, JumpE, ValidE, ResultSrcE,
    output ForwardAE, ForwardBE, LoadUseStall
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding muxes for the ALU operands
// and store data, plus load-use hazard detection toward Decode/Fetch.
module id_ex_operand_stage #(
  parameter int N = 32,
  parameter int R = 5
) (
  input logic                 clk,
  input logic                 reset_n,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [N-1:0] pc;
    logic [N-1:0] imm;
    logic [R-1:0] rs1;
    logic [R-1:0] rs2;
    logic [R-1:0] rd;
    logic [2:0]   alu_ctrl;
    logic         alu_src;
    logic [1:0]   result_src;
    logic         reg_write;
    logic         mem_write;
    logic         branch;
    logic         jump;
    logic         valid;
  } e_regs_t;

  e_regs_t      e_d;
  e_regs_t      e_q;
  logic [1:0]   forward_a;
  logic [1:0]   forward_b;
  logic [N-1:0] src_a;
  logic [N-1:0] write_data;

  // Next E contents: a flush clears everything to a bubble and wins over a stall
  always_comb begin
    e_d = e_q;
    if (bus.FlushE) begin
      e_d = '0;
    end else if (!bus.StallE) begin
      e_d.rd1        = bus.RD1D;
      e_d.rd2        = bus.RD2D;
      e_d.pc         = bus.PCD;
      e_d.imm        = bus.ImmExtD;
      e_d.rs1        = bus.Rs1D;
      e_d.rs2        = bus.Rs2D;
      e_d.rd         = bus.RdD;
      e_d.alu_ctrl   = bus.ALUControlD;
      e_d.alu_src    = bus.ALUSrcD;
      e_d.result_src = bus.ResultSrcD;
      e_d.reg_write  = bus.RegWriteD;
      e_d.mem_write  = bus.MemWriteD;
      e_d.branch     = bus.BranchD;
      e_d.jump       = bus.JumpD;
      e_d.valid      = bus.ValidD;
    end
  end

  // E register bank; synchronous reset overrides stall and flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  // Forward selects: MEM is the younger producer so it beats WB; x0 never forwards
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == e_q.rs1)) begin
      forward_a = 2'b10;
    end else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == e_q.rs1)) begin
      forward_a = 2'b01;
    end
    if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == e_q.rs2)) begin
      forward_b = 2'b10;
    end else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == e_q.rs2)) begin
      forward_b = 2'b01;
    end
  end

  // Operand muxes; the unreachable 11 select falls back to the register value
  always_comb begin
    unique case (forward_a)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALUResultM;
      default: src_a = e_q.rd1;
    endcase
    unique case (forward_b)
      2'b01:   write_data = bus.ResultW;
      2'b10:   write_data = bus.ALUResultM;
      default: write_data = e_q.rd2;
    endcase
  end

  assign bus.SrcAE        = src_a;
  assign bus.WriteDataE   = write_data;
  assign bus.SrcBE        = e_q.alu_src ? e_q.imm : write_data;
  assign bus.PCE          = e_q.pc;
  assign bus.ImmExtE      = e_q.imm;
  assign bus.RdE          = e_q.rd;
  assign bus.ALUControlE  = e_q.alu_ctrl;
  assign bus.RegWriteE    = e_q.reg_write;
  assign bus.MemWriteE    = e_q.mem_write;
  assign bus.BranchE      = e_q.branch;
  assign bus.JumpE        = e_q.jump;
  assign bus.ValidE       = e_q.valid;
  assign bus.ResultSrcE   = e_q.result_src;
  assign bus.ForwardAE    = forward_a;
  assign bus.ForwardBE    = forward_b;

  // A load in E whose destination is read by the instruction in Decode
  assign bus.LoadUseStall = e_q.valid && (e_q.result_src == 2'b01) && (e_q.rd != '0) &&
                            ((e_q.rd == bus.Rs1D) || (e_q.rd == bus.Rs2D));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: table of vectors with a scoreboard queue,
// plus a hand-written sequence exercising the combinational forward paths.
module tb_id_ex_operand_stage;

  logic clk;
  logic reset_n;

  id_ex_operand_stage_if #(.N(32), .R(5)) bus ();

  id_ex_operand_stage #(.N(32), .R(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode-side inputs applied before the edge
  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alusrc;
    logic [1:0]  ressrc;
    logic        valid;
    logic        regwr;
    logic        memwr;
  } din_t;

  // Inputs applied after the edge: next Decode sources and MEM/WB forward state
  typedef struct {
    logic [4:0]  nrs1;
    logic [4:0]  nrs2;
    logic [4:0]  rdm;
    logic        regwm;
    logic [31:0] alum;
    logic [4:0]  rdw;
    logic        regww;
    logic [31:0] resw;
  } fwd_t;

  typedef struct {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] wd;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        lus;
    logic [4:0]  rd;
    logic        valid;
    logic        regwr;
    logic        memwr;
  } exp_t;

  typedef struct {
    din_t din;
    fwd_t fwd;
    exp_t exp;
  } vec_t;

  // Pass-through fields tracked by a small register model
  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  aluctl;
    logic [1:0]  ressrc;
    logic        branch;
    logic        jump;
  } mdl_t;

  typedef struct {
    exp_t e;
    mdl_t m;
  } sb_t;

  localparam int NVEC = 22;
  vec_t tab [NVEC];
  sb_t  sb_q [$];
  mdl_t model;
  int   checks = 0;
  int   errors = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one vector's pre-edge inputs and record its expected result
  task automatic apply_stimulus(input int idx);
    din_t d;
    logic [31:0] pc;
    logic [2:0]  ac;
    logic        br;
    logic        jp;
    sb_t         item;
    d  = tab[idx].din;
    pc = 32'h1000 + 32'(idx * 4);
    ac = 3'(idx % 4);
    br = 1'(idx % 2);
    jp = 1'((idx / 2) % 2);
    reset_n         = d.rst_n;
    bus.StallE      = d.stall;
    bus.FlushE      = d.flush;
    bus.RD1D        = d.rd1;
    bus.RD2D        = d.rd2;
    bus.ImmExtD     = d.imm;
    bus.PCD         = pc;
    bus.Rs1D        = d.rs1;
    bus.Rs2D        = d.rs2;
    bus.RdD         = d.rd;
    bus.ALUControlD = ac;
    bus.ALUSrcD     = d.alusrc;
    bus.ResultSrcD  = d.ressrc;
    bus.RegWriteD   = d.regwr;
    bus.MemWriteD   = d.memwr;
    bus.BranchD     = br;
    bus.JumpD       = jp;
    bus.ValidD      = d.valid;
    if (!d.rst_n || d.flush) begin
      model = '{32'h0, 32'h0, 3'h0, 2'h0, 1'b0, 1'b0};
    end else if (!d.stall) begin
      model = '{pc, d.imm, ac, d.ressrc, br, jp};
    end
    item.e = tab[idx].exp;
    item.m = model;
    sb_q.push_back(item);
  endtask

  task automatic apply_forward(input fwd_t f);
    bus.Rs1D       = f.nrs1;
    bus.Rs2D       = f.nrs2;
    bus.RdM        = f.rdm;
    bus.RegWriteM  = f.regwm;
    bus.ALUResultM = f.alum;
    bus.RdW        = f.rdw;
    bus.RegWriteW  = f.regww;
    bus.ResultW    = f.resw;
  endtask

  task automatic compare_vector(input int idx);
    sb_t item;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty vec %0d: got 0 entries, expected 1", idx);
    end else begin
      item = sb_q.pop_front();
      check_output($sformatf("v%0d SrcAE", idx),        bus.SrcAE, item.e.srca);
      check_output($sformatf("v%0d SrcBE", idx),        bus.SrcBE, item.e.srcb);
      check_output($sformatf("v%0d WriteDataE", idx),   bus.WriteDataE, item.e.wd);
      check_output($sformatf("v%0d ForwardAE", idx),    32'(bus.ForwardAE), 32'(item.e.fa));
      check_output($sformatf("v%0d ForwardBE", idx),    32'(bus.ForwardBE), 32'(item.e.fb));
      check_output($sformatf("v%0d LoadUseStall", idx), 32'(bus.LoadUseStall), 32'(item.e.lus));
      check_output($sformatf("v%0d RdE", idx),          32'(bus.RdE), 32'(item.e.rd));
      check_output($sformatf("v%0d ValidE", idx),       32'(bus.ValidE), 32'(item.e.valid));
      check_output($sformatf("v%0d RegWriteE", idx),    32'(bus.RegWriteE), 32'(item.e.regwr));
      check_output($sformatf("v%0d MemWriteE", idx),    32'(bus.MemWriteE), 32'(item.e.memwr));
      check_output($sformatf("v%0d PCE", idx),          bus.PCE, item.m.pc);
      check_output($sformatf("v%0d ImmExtE", idx),      bus.ImmExtE, item.m.imm);
      check_output($sformatf("v%0d ALUControlE", idx),  32'(bus.ALUControlE), 32'(item.m.aluctl));
      check_output($sformatf("v%0d ResultSrcE", idx),   32'(bus.ResultSrcE), 32'(item.m.ressrc));
      check_output($sformatf("v%0d BranchE", idx),      32'(bus.BranchE), 32'(item.m.branch));
      check_output($sformatf("v%0d JumpE", idx),        32'(bus.JumpE), 32'(item.m.jump));
    end
  endtask

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    // din: rst_n stall flush rd1 rd2 imm rs1 rs2 rd alusrc ressrc valid regwr memwr
    // fwd: nrs1 nrs2 rdm regwm alum rdw regww resw
    // exp: srca srcb wd fa fb lus rd valid regwr memwr
    tab[0]  = '{'{0,0,0,'hAA,'hBB,'hCC,1,2,3,1,1,1,1,1}, '{3,3,0,0,0,0,0,0},            '{0,0,0,0,0,0,0,0,0,0}};
    tab[1]  = '{'{0,1,0,'hAA,'hBB,'hCC,1,2,3,1,1,1,1,1}, '{3,3,1,1,'h5,1,1,'h6},        '{0,0,0,0,0,0,0,0,0,0}};
    tab[2]  = '{'{1,0,0,5,7,0,1,2,5,0,0,1,1,0},          '{1,2,0,0,0,0,0,0},            '{5,7,7,0,0,0,5,1,1,0}};
    tab[3]  = '{'{1,0,0,5,7,'hFFFFFFFC,1,2,5,1,0,1,1,0}, '{1,2,0,0,0,0,0,0},            '{5,'hFFFFFFFC,7,0,0,0,5,1,1,0}};
    tab[4]  = '{'{1,0,0,'h33,'h44,0,3,6,7,0,0,1,1,0},    '{0,0,3,1,'h11,3,1,'h22},      '{'h11,'h44,'h44,2,0,0,7,1,1,0}};
    tab[5]  = '{'{1,1,0,'h99,'h98,'h97,9,9,9,1,1,1,0,1}, '{0,0,3,0,'h11,3,1,'h22},      '{'h22,'h44,'h44,1,0,0,7,1,1,0}};
    tab[6]  = '{'{1,0,0,'h55,'h56,0,0,0,8,0,0,1,1,0},    '{0,0,0,1,'h11,0,1,'h22},      '{'h55,'h56,'h56,0,0,0,8,1,1,0}};
    tab[7]  = '{'{1,0,0,1,2,0,2,6,9,0,0,1,1,0},          '{0,0,6,1,'h66,2,1,'h77},      '{'h77,'h66,'h66,1,2,0,9,1,1,0}};
    tab[8]  = '{'{1,0,0,1,2,'h123,2,6,9,1,0,1,0,1},      '{0,0,6,1,'h66,2,1,'h77},      '{'h77,'h123,'h66,1,2,0,9,1,0,1}};
    tab[9]  = '{'{1,0,0,'h10,'h20,0,1,2,4,0,1,1,1,0},    '{8,4,0,0,0,0,0,0},            '{'h10,'h20,'h20,0,0,1,4,1,1,0}};
    tab[10] = '{'{1,1,0,'hE0,'hE1,'hE2,4,9,11,1,0,1,1,1},'{4,9,0,0,0,0,0,0},            '{'h10,'h20,'h20,0,0,1,4,1,1,0}};
    tab[11] = '{'{1,1,1,'hF0,'hF1,'hF2,4,4,4,1,1,1,1,1}, '{4,4,4,1,'h44,4,1,'h45},      '{0,0,0,0,0,0,0,0,0,0}};
    tab[12] = '{'{1,0,0,1,2,0,3,5,0,0,1,1,1,0},          '{0,0,0,0,0,0,0,0},            '{1,2,2,0,0,0,0,1,1,0}};
    tab[13] = '{'{1,0,0,1,2,0,3,5,4,0,1,0,1,0},          '{4,4,0,0,0,0,0,0},            '{1,2,2,0,0,0,4,0,1,0}};
    tab[14] = '{'{1,0,0,1,2,0,3,5,4,0,2,1,1,0},          '{4,4,0,0,0,0,0,0},            '{1,2,2,0,0,0,4,1,1,0}};
    tab[15] = '{'{1,0,0,9,3,0,1,2,6,0,0,1,1,1},          '{0,0,0,0,0,0,0,0},            '{9,3,3,0,0,0,6,1,1,1}};
    tab[16] = '{'{1,1,0,15,3,0,1,2,6,0,0,1,1,1},         '{0,0,0,0,0,0,0,0},            '{9,3,3,0,0,0,6,1,1,1}};
    tab[17] = '{'{1,1,1,15,3,0,1,2,6,0,0,1,1,1},         '{0,0,0,0,0,0,0,0},            '{0,0,0,0,0,0,0,0,0,0}};
    tab[18] = '{'{1,0,0,'h21,'h31,0,1,2,5,0,0,1,1,1},    '{0,0,0,0,0,0,0,0},            '{'h21,'h31,'h31,0,0,0,5,1,1,1}};
    tab[19] = '{'{0,0,0,'h22,'h32,'h5,1,2,6,1,1,1,1,1},  '{0,6,0,0,0,0,0,0},            '{0,0,0,0,0,0,0,0,0,0}};
    tab[20] = '{'{1,0,0,'h23,'h33,0,1,2,7,0,0,1,1,0},    '{0,0,0,0,0,0,0,0},            '{'h23,'h33,'h33,0,0,0,7,1,1,0}};
    tab[21] = '{'{1,0,0,'h40,'h41,0,7,8,10,0,1,1,1,0},   '{10,0,0,0,0,8,1,'h88},        '{'h40,'h88,'h88,0,1,1,10,1,1,0}};

    model = '{32'h0, 32'h0, 3'h0, 2'h0, 1'b0, 1'b0};
    reset_n = 1'b0;
    apply_forward('{0,0,0,0,0,0,0,0});

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      apply_stimulus(i);
      @(posedge clk);
      #1;
      apply_forward(tab[i].fwd);
      #1;
      compare_vector(i);
    end

    // E now holds Rs1E=7, Rs2E=8, RD1E=0x40; forward paths change with no clock edge
    bus.RdW        = 5'd0;
    bus.RegWriteW  = 1'b0;
    bus.RdM        = 5'd7;
    bus.RegWriteM  = 1'b1;
    bus.ALUResultM = 32'hAB;
    #1;
    check_output("comb M forward SrcAE", bus.SrcAE, 32'hAB);
    check_output("comb M forward ForwardAE", 32'(bus.ForwardAE), 32'h2);
    bus.RegWriteM = 1'b0;
    bus.RdW       = 5'd7;
    bus.RegWriteW = 1'b1;
    bus.ResultW   = 32'hCD;
    #1;
    check_output("comb W forward SrcAE", bus.SrcAE, 32'hCD);
    check_output("comb W forward ForwardAE", 32'(bus.ForwardAE), 32'h1);
    bus.RegWriteW = 1'b0;
    bus.RdM       = 5'd23;
    bus.RegWriteM = 1'b1;
    #1;
    check_output("full-width Rd compare ForwardAE", 32'(bus.ForwardAE), 32'h0);
    check_output("full-width Rd compare SrcAE", bus.SrcAE, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, plus the forwarding muxes that produce the ALU operands SrcA/SrcB and the store data.
- Captures decoded operands and control from Decode, resolves RAW hazards by forwarding from MEM/WB, and raises a load-use stall request toward Decode/Fetch.
- Output feeds the execute-stage ALU directly (SrcAE, SrcBE, ALUControlE).

Parameters:
- N, 32, datapath width
- R, 5, register-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- StallE  in  1  hold all E registers
- FlushE  in  1  insert bubble into E
- RD1D, RD2D, PCD, ImmExtD  in  N each  Decode operands
- Rs1D, Rs2D, RdD  in  R each  Decode register addresses
- ALUControlD  in  3  ALU op (000 add, 001 sub, 010 and, 011 or)
- ALUSrcD  in  1  1 = SrcB takes the immediate
- RegWriteD, MemWriteD, BranchD, JumpD, ValidD  in  1 each  Decode control
- ResultSrcD  in  2  00 ALU, 01 load, 10 PC+4
- ALUResultM  in  N  MEM-stage forward value
- RdM  in  R  MEM-stage destination register
- RegWriteM  in  1  MEM-stage register-write enable
- ResultW  in  N  WB-stage forward value
- RdW  in  R  WB-stage destination register
- RegWriteW  in  1  WB-stage register-write enable
- SrcAE, SrcBE  out  N  ALU operands
- WriteDataE  out  N  forwarded RD2 (store data)
- PCE, ImmExtE  out  N  registered
- RdE  out  R  registered
- ALUControlE  out  3  registered
- RegWriteE, MemWriteE, BranchE, JumpE, ValidE  out  1 each  registered
- ResultSrcE  out  2  registered
- ForwardAE, ForwardBE  out  2 each  debug/visibility
- LoadUseStall  out  1  load-use hazard request

Behaviour:
- Register update priority, evaluated at the rising edge:
  - reset_n=0: all registers clear to 0.
  - else FlushE=1: bubble. All control registers (RegWrite, MemWrite, Branch, Jump, Valid) go to 0. Data, address, ALUControl and ResultSrc registers also go to 0.
  - else StallE=1: all registers hold.
  - else: all registers load the D inputs.
- FlushE overrides StallE when both are asserted. Reset overrides both.
- Reset while a stall or flush is asserted: the reset value wins that cycle.
- Rs1E/Rs2E are kept internally for forwarding. They are not outputs.
- Forwarding is combinational, zero-latency, computed from the registered E fields and the live M/W inputs:
  - ForwardAE = 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE = 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE = 00.
  - MEM has priority over WB. x0 is never forwarded.
  - ForwardBE uses the same rule with Rs2E.
  - Select mapping: 00 → RD1E/RD2E, 01 → ResultW, 10 → ALUResultM, 11 → treat as 00 (unreachable).
- Operand outputs:
  - SrcAE = forwarded RD1.
  - WriteDataE = forwarded RD2.
  - SrcBE = ImmExtE if ALUSrcE, else WriteDataE.
- LoadUseStall = ValidE & (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). Combinational.
  - The block does not act on LoadUseStall itself. The hazard controller is responsible for driving StallD/StallF and FlushE from it.
- Bubble behaviour: a bubble has RdE=0 and ValidE=0, so it never causes a stall and is never a forward source downstream.
- Widths:
  - All comparisons are on the full R bits.
  - No arithmetic inside this block.
  - Outputs are never X after reset.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with nonzero D inputs → all registered outputs 0, SrcAE=SrcBE=0, LoadUseStall=0.
- Plain load: RD1D=5, RD2D=7, ALUSrcD=0, Rs1D=1, Rs2D=2, RegWriteM=RegWriteW=0 → next cycle SrcAE=5, SrcBE=7, ForwardAE=ForwardBE=00. Then ALUSrcD=1, ImmExtD=0xFFFF_FFFC → SrcBE=0xFFFF_FFFC, WriteDataE=7.
- Forward priority: Rs1E=3, RdM=3, RegWriteM=1, ALUResultM=0x11, RdW=3, RegWriteW=1, ResultW=0x22 → SrcAE=0x11, ForwardAE=10. Drop RegWriteM → SrcAE=0x22, ForwardAE=01. Set RdM=RdW=0 with Rs1E=0 → ForwardAE=00.
- Load-use: E holds a load (ResultSrcE=01, RdE=4, ValidE=1), Rs2D=4 → LoadUseStall=1. With RdE=0 → 0. With ValidE=0 → 0.
- Stall/flush: load RD1D=9, then StallE=1 with RD1D=15 → RD1 holds 9 (SrcAE=9). Then StallE=1 and FlushE=1 together → next cycle RegWriteE=MemWriteE=ValidE=0, SrcAE=0.
- Reset mid-operation: FlushE=0, StallE=0, valid op in flight, reset_n=0 for one cycle → all outputs 0 next edge. Normal loading resumes the cycle after reset_n returns to 1.
